ps2_receptor: RTL and testbench

PS/2 keyboard frame receiver for the keyboard peripheral. It takes the raw `ps2_clk` and `ps2_data` pins and synchronises and de-glitches them. It then deserialises 11-bit frames with parity checking and folds the E0/F0 prefix bytes into flags. The output is one make/break code per key event, delivered as a one-cycle `code_new` strobe to the ASCII decoder and the keyboard output register.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_filtro.sv | 46 ++++
 rtl/ps2_receptor.sv | 173 +++++++++++++++++
 tb/tb_ps2_receptor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_estado_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int PS2_FILTER_LEN_DEF  = 8;
  localparam int PS2_TIMEOUT_CYC_DEF = 2000;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic paridad_impar_ok(input logic [7:0] dato, input logic par);
    return ^{dato, par};
  endfunction

endpackage

// File: rtl/ps2_filtro.sv
// Two-flop synchroniser followed by a run-length filter; the level changes
// only after FILTER_LEN consecutive synchronised samples disagree with it.
module ps2_filtro
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic nivel_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Synchronise the pin and flip the filtered level after a long enough run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign nivel_o = r_filt;

endmodule

// File: rtl/ps2_receptor.sv
// PS/2 frame receiver: conditioned pins, 11-bit frame FSM with watchdog,
// and E0/F0 prefix folding into one strobed make/break code per key event.
module ps2_receptor
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_reloj_i,
  input  logic       ps2_data_i,
  output logic [7:0] ps2_code_o,
  output logic       ps2_code_new_o,
  output logic       break_o,
  output logic       ext_o,
  output logic       frame_err_o,
  output logic       timeout_o
);

  localparam int WW = $clog2(TIMEOUT_CYC);

  logic          w_clk_f;
  logic          w_dat_f;
  logic          w_fall;
  logic          w_accept;
  logic          w_err;
  logic          w_to;

  logic          r_clk_prev;
  ps2_estado_t   r_estado;
  logic [2:0]    r_nbit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [WW-1:0] r_wd;

  logic [7:0]    r_code;
  logic          r_code_new;
  logic          r_break;
  logic          r_ext;
  logic          r_frame_err;
  logic          r_timeout;
  logic          r_ext_pend;
  logic          r_brk_pend;

  ps2_filtro #(.FILTER_LEN(FILTER_LEN)) u_filtro_reloj (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (ps2_reloj_i),
    .nivel_o (w_clk_f)
  );

  ps2_filtro #(.FILTER_LEN(FILTER_LEN)) u_filtro_data (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (ps2_data_i),
    .nivel_o (w_dat_f)
  );

  assign w_fall = r_clk_prev & ~w_clk_f;

  // Frame outcome for this cycle; a fall always takes priority over the watchdog.
  always_comb begin
    w_accept = 1'b0;
    w_err    = 1'b0;
    w_to     = 1'b0;
    if (w_fall) begin
      if (r_estado == STOP) begin
        if (w_dat_f && paridad_impar_ok(r_shift, r_par)) begin
          w_accept = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end else begin
        w_accept = 1'b0;
      end
    end else if ((r_estado != IDLE) && (r_wd == WW'(TIMEOUT_CYC - 1))) begin
      w_to = 1'b1;
    end else begin
      w_to = 1'b0;
    end
  end

  // Frame FSM and inter-edge watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clk_prev <= 1'b1;
      r_estado   <= IDLE;
      r_nbit     <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_clk_prev <= w_clk_f;
      if (w_fall) begin
        r_wd <= '0;
        case (r_estado)
          IDLE: begin
            if (!w_dat_f) begin
              r_estado <= DATA;
              r_nbit   <= 3'd0;
            end
          end
          DATA: begin
            r_shift <= {w_dat_f, r_shift[7:1]};
            r_nbit  <= r_nbit + 3'd1;
            if (r_nbit == 3'd7) begin
              r_estado <= PARITY;
            end
          end
          PARITY: begin
            r_par    <= w_dat_f;
            r_estado <= STOP;
          end
          STOP:    r_estado <= IDLE;
          default: r_estado <= IDLE;
        endcase
      end else if (r_estado == IDLE) begin
        r_wd <= '0;
      end else if (w_to) begin
        r_estado <= IDLE;
        r_wd     <= '0;
        r_nbit   <= 3'd0;
        r_shift  <= 8'h00;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  // Prefix folding and registered output strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_code      <= 8'h00;
      r_code_new  <= 1'b0;
      r_break     <= 1'b0;
      r_ext       <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
    end else begin
      r_code_new  <= 1'b0;
      r_frame_err <= w_err;
      r_timeout   <= w_to;
      if (w_err || w_to) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_accept) begin
        if (r_shift == PS2_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == PS2_BRK) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_code     <= r_shift;
          r_ext      <= r_ext_pend;
          r_break    <= r_brk_pend;
          r_code_new <= 1'b1;
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  assign ps2_code_o     = r_code;
  assign ps2_code_new_o = r_code_new;
  assign break_o        = r_break;
  assign ext_o          = r_ext;
  assign frame_err_o    = r_frame_err;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_ps2_receptor.sv
// Bench for ps2_receptor: directed scenarios plus randomized frames checked
// against an event-level model of the prefix and error rules.
module tb_ps2_receptor;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;

  typedef struct packed {
    logic [1:0] kind;   // 0 code, 1 frame error, 2 timeout
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] code;
  logic       code_new;
  logic       brk;
  logic       ext;
  logic       ferr;
  logic       tout;

  ev_t obs[$];
  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  multi   = 0;
  bit  m_ext;
  bit  m_brk;

  ps2_receptor #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ps2_reloj_i    (ps2_clk),
    .ps2_data_i     (ps2_dat),
    .ps2_code_o     (code),
    .ps2_code_new_o (code_new),
    .break_o        (brk),
    .ext_o          (ext),
    .frame_err_o    (ferr),
    .timeout_o      (tout)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle as an event; overlapping strobes are tallied.
  always @(negedge clk) begin
    if (!rst) begin
      if ((int'(code_new) + int'(ferr) + int'(tout)) > 1) multi++;
      if (code_new) obs.push_back({2'd0, code, brk, ext});
      if (ferr)     obs.push_back({2'd1, 8'h00, 1'b0, 1'b0});
      if (tout)     obs.push_back({2'd2, 8'h00, 1'b0, 1'b0});
    end
  end

  function automatic ev_t mk(input logic [1:0] k, input logic [7:0] c, input logic b, input logic e);
    return {k, c, b, e};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame (or its first nbits bits), optional clock glitch after bit glitch_at.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input int nbits, input int glitch_at, input bit stall);
    logic [10:0] f;
    f = {~bad_stop, (~(^b)) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
      end
    end
    ps2_dat = 1'b1;
    if (stall && nbits < 11) wait_cyc(TO + 50);
    wait_cyc(30);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back(mk(2'd1, 8'h00, 1'b0, 1'b0));
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back(mk(2'd0, b, m_brk, m_ext));
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    n_tests++;
    if ({code, brk, ext} !== 10'h000) begin
      n_fail++; $display("FAIL reset_outputs got code=%h brk=%b ext=%b want 00 0 0", code, brk, ext);
    end
    n_tests++;
    if ({code_new, ferr, tout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000", {code_new, ferr, tout});
    end
  endtask

  task automatic test_single;
    obs.delete();
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 1) begin
      n_fail++; $display("FAIL single_count got %0d want 1", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd0, 8'h1C, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL single_event got %h want %h", obs[0], mk(2'd0, 8'h1C, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_break;
    obs.delete();
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 2) begin
      n_fail++; $display("FAIL break_count got %0d want 2", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd0, 8'h1C, 1'b1, 1'b0)) begin
        n_fail++; $display("FAIL break_event got %h want %h", obs[0], mk(2'd0, 8'h1C, 1'b1, 1'b0));
      end
      n_tests++;
      if (obs[1] !== mk(2'd0, 8'h1C, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL break_cleared got %h want %h", obs[1], mk(2'd0, 8'h1C, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_ext_break;
    obs.delete();
    send_frame(8'hE0, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 1) begin
      n_fail++; $display("FAIL ext_break_count got %0d want 1", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd0, 8'h75, 1'b1, 1'b1)) begin
        n_fail++; $display("FAIL ext_break_event got %h want %h", obs[0], mk(2'd0, 8'h75, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_parity_err;
    obs.delete();
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (code !== 8'h75) begin
      n_fail++; $display("FAIL code_hold got %h want 75", code);
    end
    send_frame(8'h32, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 2) begin
      n_fail++; $display("FAIL parity_count got %0d want 2", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd1, 8'h00, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL parity_err got %h want %h", obs[0], mk(2'd1, 8'h00, 1'b0, 1'b0));
      end
      n_tests++;
      if (obs[1] !== mk(2'd0, 8'h32, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL parity_recover got %h want %h", obs[1], mk(2'd0, 8'h32, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_timeout;
    obs.delete();
    send_frame(8'h1C, 1'b0, 1'b0, 6, -1, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 3, -1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 3) begin
      n_fail++; $display("FAIL timeout_count got %0d want 3", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd2, 8'h00, 1'b0, 1'b0) || obs[1] !== mk(2'd2, 8'h00, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL timeout_event got %h %h want %h", obs[0], obs[1], mk(2'd2, 8'h00, 1'b0, 1'b0));
      end
      n_tests++;
      if (obs[2] !== mk(2'd0, 8'h1C, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL timeout_clears_break got %h want %h", obs[2], mk(2'd0, 8'h1C, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_glitch;
    obs.delete();
    send_frame(8'h5A, 1'b0, 1'b0, 11, 3, 1'b0);
    n_tests++;
    if (obs.size() !== 1) begin
      n_fail++; $display("FAIL glitch_count got %0d want 1", obs.size());
    end else begin
      n_tests++;
      if (obs[0] !== mk(2'd0, 8'h5A, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL glitch_event got %h want %h", obs[0], mk(2'd0, 8'h5A, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid;
    obs.delete();
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 5, -1, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    n_tests++;
    if ({code, brk, ext, code_new, ferr, tout} !== 13'h0000) begin
      n_fail++; $display("FAIL reset_mid_outputs got code=%h flags=%b want 00 00000", code,
                         {brk, ext, code_new, ferr, tout});
    end
    rst = 1'b0;
    wait_cyc(TO + 50);
    n_tests++;
    if (obs.size() !== 0) begin
      n_fail++; $display("FAIL reset_mid_silent got %0d events want 0", obs.size());
    end
    send_frame(8'h29, 1'b0, 1'b0, 11, -1, 1'b0);
    n_tests++;
    if (obs.size() !== 1 || obs[0] !== mk(2'd0, 8'h29, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_next got %0d events first %h want 1 %h", obs.size(),
                         (obs.size() > 0) ? obs[0] : 11'h0, mk(2'd0, 8'h29, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random;
    int          r;
    logic [7:0]  b;
    obs.delete();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 99));
      b = (r < 15) ? 8'hE0 : (r < 30) ? 8'hF0 : 8'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        model_frame(b, 1'b1);
        send_frame(b, 1'b0, 1'b0, 11, -1, 1'b0);
      end else if (r < 82) begin
        model_frame(b, 1'b0);
        send_frame(b, 1'b1, 1'b0, 11, -1, 1'b0);
      end else if (r < 92) begin
        model_frame(b, 1'b0);
        send_frame(b, 1'($urandom_range(0, 1)), 1'b1, 11, -1, 1'b0);
      end else begin
        exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(b, 1'b0, 1'b0, int'($urandom_range(1, 10)), -1, 1'b1);
      end
    end
    n_tests++;
    if (obs.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count got %0d want %0d", obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    n_tests++;
    if (multi !== 0) begin
      n_fail++; $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", multi);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
